// File: rtl/spi_rx_pingpong_ctrl.sv
// Ping-pong sequencer for the 512-byte SPI receive buffer: writes the SPI byte stream
// into the free 256-byte bank and presents filled banks to the reader in order.
module spi_rx_pingpong_ctrl #(
   parameter int BankBytes = 256
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       StartFill,
   input  logic [8:0] FillLen,
   output logic       FillAck,
   input  logic       Abort,
   input  logic       RxValid,
   input  logic [7:0] RxData,
   output logic       RxReady,
   output logic       FillBusy,
   output logic       RamWriteEnable,
   output logic [8:0] RamWriteAddr,
   output logic [7:0] RamWriteData,
   output logic       RdValid,
   output logic       RdBank,
   output logic [8:0] RdLen,
   input  logic [6:0] ConsWordAddr,
   output logic [7:0] RamReadAddr,
   input  logic       Release
);

   localparam logic [8:0] LP_BANK_LEN = 9'(BankBytes);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_COMMIT} state_t;

   state_t          r_state, w_next;
   logic            r_wr_bank, r_rd_bank;
   logic [1:0]      r_full, w_full_nxt;
   logic [1:0][8:0] r_len;
   logic [8:0]      r_count, r_fill_len, w_len_clamp;
   logic            r_we;
   logic [8:0]      r_wa;
   logic [7:0]      r_wd;
   logic            w_start, w_accept, w_last, w_release;

   assign w_len_clamp = (FillLen == 9'd0 || FillLen > LP_BANK_LEN) ? LP_BANK_LEN : FillLen;
   // Full is sampled registered, so a bank released this cycle is fillable next cycle
   assign w_start     = (r_state == ST_IDLE) && StartFill && !r_full[r_wr_bank];
   assign w_accept    = RxValid && (r_state == ST_FILL);
   assign w_last      = w_accept && ((r_count + 9'd1) == r_fill_len);
   assign w_release   = Release && r_full[r_rd_bank];

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_start) w_next = ST_FILL;
         ST_FILL: begin
            if (Abort)       w_next = ST_IDLE;
            else if (w_last) w_next = ST_COMMIT;
         end
         ST_COMMIT: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Commit and release always touch different banks, so both apply
   always_comb begin
      w_full_nxt = r_full;
      if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
      if (r_state == ST_COMMIT) w_full_nxt[r_wr_bank] = 1'b1;
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state    <= ST_IDLE;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_full     <= '0;
         r_len      <= '0;
         r_count    <= '0;
         r_fill_len <= '0;
         r_we       <= 1'b0;
         r_wa       <= '0;
         r_wd       <= '0;
      end else begin
         r_state <= w_next;
         r_full  <= w_full_nxt;
         r_we    <= w_accept;
         if (w_start) begin
            r_count    <= '0;
            r_fill_len <= w_len_clamp;
         end else if (w_accept) begin
            r_count <= r_count + 9'd1;
         end
         if (w_accept) begin
            r_wa <= {r_wr_bank, r_count[7:0]};
            r_wd <= RxData;
         end
         if (r_state == ST_COMMIT) begin
            r_len[r_wr_bank] <= r_fill_len;
            r_wr_bank        <= ~r_wr_bank;
         end
         if (w_release) r_rd_bank <= ~r_rd_bank;
      end
   end

   assign FillAck        = w_start;
   assign RxReady        = (r_state == ST_FILL);
   assign FillBusy       = (r_state == ST_FILL);
   assign RamWriteEnable = r_we;
   assign RamWriteAddr   = r_wa;
   assign RamWriteData   = r_wd;
   assign RdValid        = r_full[r_rd_bank];
   assign RdBank         = r_rd_bank;
   assign RdLen          = r_len[r_rd_bank];
   assign RamReadAddr    = {r_rd_bank, ConsWordAddr};

endmodule

// File: tb/tb_spi_rx_pingpong_ctrl.sv
// Directed bench for spi_rx_pingpong_ctrl: per-cycle vector table plus multi-cycle
// sequences for full-length fills, abort, throttled input and reset.
module tb_spi_rx_pingpong_ctrl;

   logic       Clk = 1'b0;
   logic       nReset;
   logic       StartFill, Abort, RxValid, Release;
   logic [8:0] FillLen;
   logic [7:0] RxData;
   logic [6:0] ConsWordAddr;
   logic       FillAck, RxReady, FillBusy, RamWriteEnable, RdValid, RdBank;
   logic [8:0] RamWriteAddr, RdLen;
   logic [7:0] RamWriteData, RamReadAddr;

   int checks = 0;
   int errors = 0;

   spi_rx_pingpong_ctrl #(.BankBytes(256)) dut (
      .Clk(Clk), .nReset(nReset), .StartFill(StartFill), .FillLen(FillLen),
      .FillAck(FillAck), .Abort(Abort), .RxValid(RxValid), .RxData(RxData),
      .RxReady(RxReady), .FillBusy(FillBusy), .RamWriteEnable(RamWriteEnable),
      .RamWriteAddr(RamWriteAddr), .RamWriteData(RamWriteData), .RdValid(RdValid),
      .RdBank(RdBank), .RdLen(RdLen), .ConsWordAddr(ConsWordAddr),
      .RamReadAddr(RamReadAddr), .Release(Release)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       start;
      logic [8:0] len;
      logic       rxv;
      logic [7:0] rxd;
      logic       rel;
      logic       ack, rxr, busy, we;
      logic [8:0] wa;
      logic [7:0] wd;
      logic       rdv, rdb;
      logic [8:0] rdl;
      logic [7:0] rra;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      nReset = 1'b0;
      StartFill = 0; Abort = 0; RxValid = 0; Release = 0; FillLen = 0; RxData = 0;
      @(negedge Clk);
      nReset = 1'b1;
      #1;
   endtask

   task automatic do_release();
      @(negedge Clk);
      Release = 1'b1;
      @(negedge Clk);
      Release = 1'b0;
      #1;
   endtask

   // Runs one fill: n bytes offered (every other cycle if tog), data seed+k for byte k.
   // bad counts out-of-order addresses, wrong data and writes not following an accept.
   task automatic fill(input logic [8:0] len, input int n, input bit tog, input logic [7:0] seed,
                       output int wrs, output logic [8:0] fa, output logic [8:0] la, output int bad);
      int sent = 0;
      int cyc  = 0;
      bit pacc = 0;
      wrs = 0; bad = 0; fa = '0; la = '0;
      @(negedge Clk);
      StartFill = 1'b1; FillLen = len;
      #1 chk("fill.ack", 32'(FillAck), 32'd1);
      @(negedge Clk);
      StartFill = 1'b0;
      while (!(sent == n && !pacc)) begin
         if (cyc >= 1000) begin
            chk("fill.timeout", 32'd0, 32'd1);
            break;
         end
         RxValid = (sent < n) && (!tog || (cyc % 2 == 0));
         RxData  = seed + 8'(sent);
         #1;
         if (RamWriteEnable !== pacc) bad++;
         if (RamWriteEnable) begin
            if (wrs == 0) fa = RamWriteAddr;
            else if (RamWriteAddr !== 9'(la + 9'd1)) bad++;
            if (RamWriteData !== seed + 8'(wrs)) bad++;
            la = RamWriteAddr;
            wrs++;
         end
         pacc = RxValid && RxReady;
         if (pacc) sent++;
         cyc++;
         @(negedge Clk);
      end
      RxValid = 1'b0;
      #1;
   endtask

   int          wrs, bad;
   logic [8:0]  fa, la;

   initial begin
      //         st len    rxv rxd    rel ack rxr bsy we  wa      wd     rdv rdb rdl    rra
      vt[0]  = '{1, 9'd4,  0, 8'h00, 0,  1,  0,  0,  0, 9'h000, 8'h00, 0,  0,  9'd0, 8'h05};
      vt[1]  = '{0, 9'd4,  1, 8'h11, 0,  0,  1,  1,  0, 9'h000, 8'h00, 0,  0,  9'd0, 8'h05};
      vt[2]  = '{0, 9'd4,  1, 8'h22, 0,  0,  1,  1,  1, 9'h000, 8'h11, 0,  0,  9'd0, 8'h05};
      vt[3]  = '{0, 9'd4,  1, 8'h33, 0,  0,  1,  1,  1, 9'h001, 8'h22, 0,  0,  9'd0, 8'h05};
      vt[4]  = '{0, 9'd4,  1, 8'h44, 0,  0,  1,  1,  1, 9'h002, 8'h33, 0,  0,  9'd0, 8'h05};
      vt[5]  = '{0, 9'd4,  0, 8'h00, 0,  0,  0,  0,  1, 9'h003, 8'h44, 0,  0,  9'd0, 8'h05};
      vt[6]  = '{0, 9'd4,  0, 8'h00, 0,  0,  0,  0,  0, 9'h000, 8'h00, 1,  0,  9'd4, 8'h05};
      vt[7]  = '{1, 9'd2,  0, 8'h00, 0,  1,  0,  0,  0, 9'h000, 8'h00, 1,  0,  9'd4, 8'h05};
      vt[8]  = '{0, 9'd2,  1, 8'hAA, 0,  0,  1,  1,  0, 9'h000, 8'h00, 1,  0,  9'd4, 8'h05};
      vt[9]  = '{0, 9'd2,  1, 8'hBB, 0,  0,  1,  1,  1, 9'h100, 8'hAA, 1,  0,  9'd4, 8'h05};
      vt[10] = '{0, 9'd2,  0, 8'h00, 0,  0,  0,  0,  1, 9'h101, 8'hBB, 1,  0,  9'd4, 8'h05};
      vt[11] = '{0, 9'd2,  0, 8'h00, 0,  0,  0,  0,  0, 9'h000, 8'h00, 1,  0,  9'd4, 8'h05};
      vt[12] = '{1, 9'd5,  0, 8'h00, 0,  0,  0,  0,  0, 9'h000, 8'h00, 1,  0,  9'd4, 8'h05};
      vt[13] = '{1, 9'd5,  0, 8'h00, 1,  0,  0,  0,  0, 9'h000, 8'h00, 1,  0,  9'd4, 8'h05};
      vt[14] = '{1, 9'd5,  0, 8'h00, 0,  1,  0,  0,  0, 9'h000, 8'h00, 1,  1,  9'd2, 8'h85};
      vt[15] = '{0, 9'd5,  1, 8'hCC, 0,  0,  1,  1,  0, 9'h000, 8'h00, 1,  1,  9'd2, 8'h85};
      vt[16] = '{0, 9'd5,  0, 8'h00, 0,  0,  1,  1,  1, 9'h000, 8'hCC, 1,  1,  9'd2, 8'h85};

      nReset = 1'b0;
      StartFill = 0; Abort = 0; RxValid = 0; Release = 0; FillLen = 0; RxData = 0;
      ConsWordAddr = 7'h05;
      repeat (2) @(negedge Clk);
      #1;
      chk("rst.ack",   32'(FillAck), 0);
      chk("rst.rxr",   32'(RxReady), 0);
      chk("rst.busy",  32'(FillBusy), 0);
      chk("rst.we",    32'(RamWriteEnable), 0);
      chk("rst.wa",    32'(RamWriteAddr), 0);
      chk("rst.rdv",   32'(RdValid), 0);
      chk("rst.rdb",   32'(RdBank), 0);
      chk("rst.rdl",   32'(RdLen), 0);
      chk("rst.rra",   32'(RamReadAddr), 32'h05);
      nReset = 1'b1;

      for (int i = 0; i < 17; i++) begin
         @(negedge Clk);
         StartFill = vt[i].start; FillLen = vt[i].len; RxValid = vt[i].rxv;
         RxData = vt[i].rxd; Release = vt[i].rel;
         #1;
         chk($sformatf("v%0d.ack", i),  32'(FillAck),  32'(vt[i].ack));
         chk($sformatf("v%0d.rxr", i),  32'(RxReady),  32'(vt[i].rxr));
         chk($sformatf("v%0d.busy", i), 32'(FillBusy), 32'(vt[i].busy));
         chk($sformatf("v%0d.we", i),   32'(RamWriteEnable), 32'(vt[i].we));
         if (vt[i].we) begin
            chk($sformatf("v%0d.wa", i), 32'(RamWriteAddr), 32'(vt[i].wa));
            chk($sformatf("v%0d.wd", i), 32'(RamWriteData), 32'(vt[i].wd));
         end
         chk($sformatf("v%0d.rdv", i), 32'(RdValid), 32'(vt[i].rdv));
         chk($sformatf("v%0d.rdb", i), 32'(RdBank),  32'(vt[i].rdb));
         chk($sformatf("v%0d.rdl", i), 32'(RdLen),   32'(vt[i].rdl));
         chk($sformatf("v%0d.rra", i), 32'(RamReadAddr), 32'(vt[i].rra));
      end
      StartFill = 0; RxValid = 0; Release = 0;

      // FillLen=0 means a full 256-byte bank, in both banks
      do_reset();
      fill(9'd0, 256, 1'b0, 8'h00, wrs, fa, la, bad);
      chk("len0.b0.wrs", 32'(wrs), 256);
      chk("len0.b0.first", 32'(fa), 32'h000);
      chk("len0.b0.last", 32'(la), 32'h0FF);
      chk("len0.b0.bad", 32'(bad), 0);
      chk("len0.b0.rxr", 32'(RxReady), 0);
      chk("len0.b0.rdv", 32'(RdValid), 1);
      chk("len0.b0.rdl", 32'(RdLen), 32'h100);
      fill(9'd0, 256, 1'b0, 8'h40, wrs, fa, la, bad);
      chk("len0.b1.wrs", 32'(wrs), 256);
      chk("len0.b1.first", 32'(fa), 32'h100);
      chk("len0.b1.last", 32'(la), 32'h1FF);
      chk("len0.b1.bad", 32'(bad), 0);
      do_release();
      chk("len0.b1.rdb", 32'(RdBank), 1);
      chk("len0.b1.rdl", 32'(RdLen), 32'h100);

      // Abort after 5 of 10 bytes; next fill reuses bank 0 from index 0
      do_reset();
      fill(9'd10, 5, 1'b0, 8'h10, wrs, fa, la, bad);
      chk("abort.pre.wrs", 32'(wrs), 5);
      @(negedge Clk);
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      #1;
      chk("abort.rxr", 32'(RxReady), 0);
      chk("abort.busy", 32'(FillBusy), 0);
      chk("abort.rdv", 32'(RdValid), 0);
      fill(9'd3, 3, 1'b0, 8'h20, wrs, fa, la, bad);
      chk("abort.refill.first", 32'(fa), 32'h000);
      chk("abort.refill.last", 32'(la), 32'h002);
      chk("abort.refill.rdl", 32'(RdLen), 3);

      // Throttled input: RxValid alternates, writes only after accepted bytes
      fill(9'd6, 6, 1'b1, 8'h30, wrs, fa, la, bad);
      chk("tog.wrs", 32'(wrs), 6);
      chk("tog.first", 32'(fa), 32'h100);
      chk("tog.last", 32'(la), 32'h105);
      chk("tog.bad", 32'(bad), 0);
      do_release();
      chk("tog.rdb", 32'(RdBank), 1);
      chk("tog.rdl", 32'(RdLen), 6);
      chk("tog.rra", 32'(RamReadAddr), 32'h85);

      // Reset with both banks full, then reset in the middle of a fill
      fill(9'd2, 2, 1'b0, 8'h50, wrs, fa, la, bad);
      chk("both.first", 32'(fa), 32'h000);
      chk("both.rdv", 32'(RdValid), 1);
      chk("both.rdb", 32'(RdBank), 1);
      @(negedge Clk);
      nReset = 1'b0;
      #1;
      chk("rstfull.rdv", 32'(RdValid), 0);
      chk("rstfull.rdb", 32'(RdBank), 0);
      chk("rstfull.rdl", 32'(RdLen), 0);
      chk("rstfull.rra", 32'(RamReadAddr), 32'h05);
      chk("rstfull.we", 32'(RamWriteEnable), 0);
      @(negedge Clk);
      nReset = 1'b1;
      fill(9'd8, 3, 1'b0, 8'h60, wrs, fa, la, bad);
      chk("mid.busy.pre", 32'(FillBusy), 1);
      @(negedge Clk);
      nReset = 1'b0;
      #1;
      chk("mid.busy", 32'(FillBusy), 0);
      chk("mid.rxr", 32'(RxReady), 0);
      chk("mid.wa", 32'(RamWriteAddr), 0);
      @(negedge Clk);
      nReset = 1'b1;
      fill(9'd2, 2, 1'b0, 8'h70, wrs, fa, la, bad);
      chk("mid.refill.first", 32'(fa), 32'h000);
      chk("mid.refill.rdb", 32'(RdBank), 0);
      chk("mid.refill.rdl", 32'(RdLen), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_rx_pingpong_ctrl.md
Name: spi_rx_pingpong_ctrl

Overview:
- Sequences the 512-byte receive buffer (8-bit write port, 16-bit read port) as two 256-byte ping-pong banks.
- Accepts a byte stream from the SPI receiver and writes it into the free bank, then hands each filled bank to the cartridge-bus reader.
- The reader frees a bank with a release pulse.
- Sits between the SPI RX shifter and the buffer RAM, in the RAM write clock domain.

Parameters:
- BankBytes, 256, bytes per bank; fixed at 256 so the bank select is write address bit 8 / read address bit 7.

Ports:
- Clk  in  1  system clock; RAM write clock.
- nReset  in  1  asynchronous active-low reset.
- StartFill  in  1  level request to fill the next bank; held until FillAck.
- FillLen  in  9  byte count for the fill; valid 1..256; 0 or >256 treated as 256.
- FillAck  out  1  one-cycle pulse when StartFill is accepted.
- Abort  in  1  pulse; cancels an in-progress fill.
- RxValid  in  1  byte available from the SPI receiver.
- RxData  in  8  received byte.
- RxReady  out  1  controller accepts RxData this cycle.
- FillBusy  out  1  a fill is in progress.
- RamWriteEnable  out  1  to RAM write port.
- RamWriteAddr  out  9  to RAM write port: {bank, byte index}.
- RamWriteData  out  8  to RAM write port.
- RdValid  out  1  bank RdBank is full and readable.
- RdBank  out  1  bank currently presented to the reader.
- RdLen  out  9  byte count stored for RdBank (1..256).
- ConsWordAddr  in  7  reader word address within a bank.
- RamReadAddr  out  8  combinational {RdBank, ConsWordAddr} to RAM read port.
- Release  in  1  pulse; reader is done with RdBank.

Behaviour:
- Reset (async, nReset low):
  - Writer state IDLE; WrBank=0, RdBank=0; Full[1:0]=0; Len[*]=0; count=0.
  - All outputs 0, except RamReadAddr = {0, ConsWordAddr}.
- Writer FSM: IDLE, FILL, COMMIT.
  - IDLE:
    - RxReady=0.
    - If StartFill && !Full[WrBank]: FillAck=1 for that cycle; latch len (clamped); count=0; go to FILL.
    - If StartFill && Full[WrBank]: no ack; request stays pending.
  - FILL:
    - RxReady=1, FillBusy=1.
    - On RxValid&&RxReady:
      - Next cycle register RamWriteEnable=1, RamWriteAddr={WrBank, count[7:0]}, RamWriteData=RxData.
      - count increments.
    - If the accepted byte is byte number len, go to COMMIT; RxReady is 0 from the next cycle.
    - Abort in FILL: go to IDLE; bank not marked full; data discarded; a byte accepted in the same cycle as Abort is still written.
  - COMMIT (exactly 1 cycle):
    - RxReady=0; RamWriteEnable carries the last byte.
    - At the end of the cycle: Full[WrBank]=1, Len[WrBank]=len, WrBank toggles, go to IDLE.
    - RdValid for that bank is therefore visible no earlier than 1 cycle after its last RAM write.
- RamWriteEnable is 0 in every cycle not following an accepted byte.
- Reader side:
  - RdValid = Full[RdBank]; RdLen = Len[RdBank].
  - Release while RdValid: clear Full[RdBank], toggle RdBank next edge.
  - Release while !RdValid: ignored.
- Simultaneous events:
  - COMMIT and Release in the same cycle touch different banks; both take effect.
  - StartFill is evaluated against registered Full, so a bank released in cycle N is fillable from cycle N+1.
- Ordering: banks are filled and presented strictly alternately (0,1,0,1...), so RdBank always names the oldest full bank.
- Abort outside FILL: ignored.
- Reset mid-fill: everything returns to reset values; partial data is abandoned.
- Throughput: 1 byte per cycle in FILL; 2 idle cycles (COMMIT, IDLE) between back-to-back fills.

Test Plan:
- Reset, then StartFill with FillLen=4, bytes 11,22,33,44 back-to-back -> FillAck pulse; writes to addrs 0x000..0x003; RdValid=1, RdBank=0, RdLen=4 one cycle after COMMIT; WrBank=1.
- Fill bank 0 (len 2) and bank 1 (len 3) without Release -> third StartFill gets no FillAck and RxReady stays 0. Release -> RdBank=1, RdLen=3; next cycle FillAck and writes go to 0x000.
- FillLen=0 -> exactly 256 bytes accepted, last write at addr 0x0FF (bank 0) or 0x1FF (bank 1), RdLen=256.
- Abort after 5 of 10 bytes -> state IDLE, RxReady=0, Full unchanged, RdValid=0; next fill reuses the same bank from index 0.
- RxValid toggling 1/0 every cycle during a 6-byte fill -> exactly 6 writes at consecutive addresses, no write on idle cycles. ConsWordAddr=0x05 with RdBank=1 -> RamReadAddr=0x85.
- Assert nReset low mid-fill with both Full set -> all flags and outputs cleared immediately; after release, first fill targets bank 0.
